axil_cmd_master: RTL and testbench

AXI4-Lite initiator that turns single register commands from a local command port into AXI4-Lite write or read transactions. It has one transaction outstanding at a time. An optional poll mode repeats a read until a masked field matches. The block sits on the host/sequencer side of the accelerator's AXI4-Lite control slave. It drives the ap_start/rst_n control word, the arguments and the BAR registers, and polls the status word at 0x10 for ap_done/ap_idle.

---
 rtl/axil_cmd_master.sv | 212 +++++++++++++++++++++
 tb/tb_axil_cmd_master.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_cmd_master.sv
// AXI4-Lite initiator: turns single commands from a local port into AXI4-Lite
// writes or reads, with an optional poll mode that re-reads until a masked match.
module axil_cmd_master #(
  parameter int C_ADDR_WIDTH = 8,
  parameter int C_DATA_WIDTH = 32,
  parameter int POLL_MAX     = 1024
) (
  input  logic                      ACLK,
  input  logic                      ARESETN,
  // Command port
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic                      cmd_poll,
  input  logic [C_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_DATA_WIDTH/8-1:0] cmd_wstrb,
  input  logic [C_DATA_WIDTH-1:0]   cmd_mask,
  input  logic [C_DATA_WIDTH-1:0]   cmd_match,
  // Response port
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [C_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                rsp_resp,
  output logic                      rsp_timeout,
  // AXI4-Lite write address / data / response
  output logic [C_ADDR_WIDTH-1:0]   AWADDR,
  output logic                      AWVALID,
  input  logic                      AWREADY,
  output logic [C_DATA_WIDTH-1:0]   WDATA,
  output logic [C_DATA_WIDTH/8-1:0] WSTRB,
  output logic                      WVALID,
  input  logic                      WREADY,
  input  logic [1:0]                BRESP,
  input  logic                      BVALID,
  output logic                      BREADY,
  // AXI4-Lite read address / data
  output logic [C_ADDR_WIDTH-1:0]   ARADDR,
  output logic                      ARVALID,
  input  logic                      ARREADY,
  input  logic [C_DATA_WIDTH-1:0]   RDATA,
  input  logic [1:0]                RRESP,
  input  logic                      RVALID,
  output logic                      RREADY,
  // Current FSM state for observation
  output logic [2:0]                dbg_state
);

  // Handshake rule on every channel (cmd, rsp, AW, W, B, AR, R): a transfer
  // happens on the rising ACLK edge where valid and ready are both high; a
  // valid, once raised, holds with stable payload until that edge, and never
  // waits for ready before rising.

  localparam int CNT_W = $clog2(POLL_MAX + 1);
  localparam logic [CNT_W-1:0] POLL_LAST = CNT_W'(POLL_MAX);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WR    = 3'd1,
    S_WRESP = 3'd2,
    S_RD    = 3'd3,
    S_RDATA = 3'd4,
    S_RSP   = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic                    is_poll_q;
  logic [C_DATA_WIDTH-1:0] mask_q;
  logic [C_DATA_WIDTH-1:0] match_q;
  logic [CNT_W-1:0]        rd_cnt_q;
  logic [CNT_W-1:0]        rd_cnt_inc;

  logic cmd_accept;
  logic aw_left;
  logic w_left;
  logic poll_hit;
  logic timeout_d;

  assign cmd_ready  = (state_q == S_IDLE);
  assign rsp_valid  = (state_q == S_RSP);
  assign dbg_state  = state_q;

  assign cmd_accept = cmd_valid && (state_q == S_IDLE);
  // A channel is still owed a handshake if its valid is up and ready is not.
  assign aw_left    = AWVALID && !AWREADY;
  assign w_left     = WVALID && !WREADY;
  assign rd_cnt_inc = rd_cnt_q + CNT_W'(1);
  assign poll_hit   = ((RDATA & mask_q) == match_q);

  // ---------------------------------------------------------------- state
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    timeout_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) state_d = cmd_write ? S_WR : S_RD;
      end
      S_WR: begin
        if (!aw_left && !w_left) state_d = S_WRESP;
      end
      S_WRESP: begin
        if (BVALID) state_d = S_RSP;
      end
      S_RD: begin
        if (ARREADY) state_d = S_RDATA;
      end
      S_RDATA: begin
        if (RVALID) begin
          if (!is_poll_q || poll_hit || (RRESP != 2'b00)) begin
            state_d = S_RSP;
          end else if (rd_cnt_inc == POLL_LAST) begin
            state_d   = S_RSP;
            timeout_d = 1'b1;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RSP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ------------------------------------------------------- write channels
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      AWVALID <= 1'b0;
      WVALID  <= 1'b0;
      BREADY  <= 1'b0;
      AWADDR  <= '0;
      WDATA   <= '0;
      WSTRB   <= '0;
    end else begin
      // AW and W retire independently; each holds until its own handshake.
      AWVALID <= (cmd_accept && cmd_write) || aw_left;
      WVALID  <= (cmd_accept && cmd_write) || w_left;
      BREADY  <= (state_d == S_WRESP);
      if (cmd_accept && cmd_write) begin
        AWADDR <= cmd_addr;
        WDATA  <= cmd_wdata;
        WSTRB  <= cmd_wstrb;
      end
    end
  end

  // -------------------------------------------------------- read channels
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ARVALID <= 1'b0;
      RREADY  <= 1'b0;
      ARADDR  <= '0;
    end else begin
      // Re-entering S_RD from S_RDATA reissues AR at the same address.
      ARVALID <= (state_d == S_RD);
      RREADY  <= (state_d == S_RDATA);
      if (cmd_accept && !cmd_write) begin
        ARADDR <= cmd_addr;
      end
    end
  end

  // ------------------------------------------------- command context regs
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      is_poll_q <= 1'b0;
      mask_q    <= '0;
      match_q   <= '0;
      rd_cnt_q  <= '0;
    end else begin
      if (cmd_accept) begin
        is_poll_q <= cmd_poll && !cmd_write;
        mask_q    <= cmd_mask;
        match_q   <= cmd_match;
        rd_cnt_q  <= '0;
      end else if ((state_q == S_RDATA) && RVALID) begin
        // Bounded by POLL_LAST through the FSM, so this never wraps.
        rd_cnt_q <= rd_cnt_inc;
      end
    end
  end

  // ------------------------------------------------------ response capture
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rsp_rdata   <= '0;
      rsp_resp    <= 2'b00;
      rsp_timeout <= 1'b0;
    end else begin
      if ((state_q == S_WRESP) && BVALID) begin
        rsp_rdata   <= '0;
        rsp_resp    <= BRESP;
        rsp_timeout <= 1'b0;
      end else if ((state_q == S_RDATA) && RVALID) begin
        rsp_rdata   <= RDATA;
        rsp_resp    <= RRESP;
        rsp_timeout <= timeout_d;
      end
    end
  end

endmodule

// File: tb/tb_axil_cmd_master.sv
// Directed bench for axil_cmd_master: behavioural register-file AXI4-Lite slave
// with per-channel stalls and a scripted read sequence for the status word.
module tb_axil_cmd_master;

  // ------------------------------------------------------ clock and reset
  logic ACLK;
  logic ARESETN;

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // ------------------------------------------------------------ DUT wires
  logic        cmd_valid, cmd_ready, cmd_write, cmd_poll;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata, cmd_mask, cmd_match;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [7:0]  AWADDR, ARADDR;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [31:0] WDATA, RDATA;
  logic [3:0]  WSTRB;
  logic [1:0]  BRESP, RRESP;
  logic [2:0]  dbg_state;

  axil_cmd_master #(
    .C_ADDR_WIDTH(8),
    .C_DATA_WIDTH(32),
    .POLL_MAX    (4)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_poll(cmd_poll), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .cmd_wstrb(cmd_wstrb), .cmd_mask(cmd_mask), .cmd_match(cmd_match),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .dbg_state(dbg_state)
  );

  // ------------------------------------------------------------ slave model
  logic [31:0] regs [16];
  logic        ap_start_o, rst_n_o;
  assign ap_start_o = regs[0][0];
  assign rst_n_o    = regs[0][1];

  int aw_delay, w_delay, ar_delay;
  int aw_stall, w_stall, ar_stall;
  int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  int aw_used, w_used, b_seen, ar_used, r_seen;
  logic [7:0]  aw_addr_cap, ar_addr_cap;
  logic [31:0] w_data_cap;
  logic [3:0]  w_strb_cap;
  logic [31:0] scr_data [8];
  logic [1:0]  scr_resp [8];
  int scr_len, scr_base;

  // Handshake monitor: counts transfers at the active edge.
  always @(posedge ACLK) begin
    if (ARESETN) begin
      if (AWVALID && AWREADY) begin aw_cnt++; aw_addr_cap = AWADDR; end
      if (WVALID && WREADY) begin w_cnt++; w_data_cap = WDATA; w_strb_cap = WSTRB; end
      if (BVALID && BREADY) b_cnt++;
      if (ARVALID && ARREADY) begin ar_cnt++; ar_addr_cap = ARADDR; end
      if (RVALID && RREADY) r_cnt++;
    end
  end

  // Slave drive on the falling edge, away from the DUT's sampling edge.
  always @(negedge ACLK) begin
    if (!ARESETN) begin
      AWREADY = 0; WREADY = 0; BVALID = 0; ARREADY = 0; RVALID = 0;
      BRESP = 0; RRESP = 0; RDATA = 0;
      aw_stall = 0; w_stall = 0; ar_stall = 0;
      aw_used = aw_cnt; w_used = w_cnt; b_seen = b_cnt; ar_used = ar_cnt; r_seen = r_cnt;
      for (int i = 0; i < 16; i++) regs[i] = 32'h0;
    end else begin
      if (AWVALID) begin
        if (aw_stall >= aw_delay) AWREADY = 1; else begin AWREADY = 0; aw_stall++; end
      end else begin AWREADY = 0; aw_stall = 0; end
      if (WVALID) begin
        if (w_stall >= w_delay) WREADY = 1; else begin WREADY = 0; w_stall++; end
      end else begin WREADY = 0; w_stall = 0; end
      if (ARVALID) begin
        if (ar_stall >= ar_delay) ARREADY = 1; else begin ARREADY = 0; ar_stall++; end
      end else begin ARREADY = 0; ar_stall = 0; end

      if (b_cnt != b_seen) begin BVALID = 0; b_seen = b_cnt; end
      if (aw_cnt != aw_used && w_cnt != w_used) begin
        for (int b = 0; b < 4; b++)
          if (w_strb_cap[b]) regs[aw_addr_cap[5:2]][8*b +: 8] = w_data_cap[8*b +: 8];
        aw_used = aw_cnt; w_used = w_cnt;
        BVALID = 1; BRESP = 2'b00;
      end

      if (r_cnt != r_seen) begin RVALID = 0; r_seen = r_cnt; end
      if (ar_cnt != ar_used) begin
        int idx;
        idx = ar_used - scr_base;
        if (ar_addr_cap == 8'h10 && idx >= 0 && idx < scr_len) begin
          RDATA = scr_data[idx]; RRESP = scr_resp[idx];
        end else begin
          RDATA = regs[ar_addr_cap[5:2]]; RRESP = 2'b00;
        end
        ar_used = ar_cnt;
        RVALID = 1;
      end
    end
  end

  // ------------------------------------------------------------ scoreboard
  int n_cmp, n_err;
  logic [31:0] exp_q [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ------------------------------------------------------------ driver tasks
  // Returns one ns after the accepting edge, i.e. in cycle T+1.
  task automatic send_cmd(input logic wr, input logic poll, input logic [7:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb,
                          input logic [31:0] mask, input logic [31:0] match);
    @(negedge ACLK);
    cmd_write = wr; cmd_poll = poll; cmd_addr = addr; cmd_wdata = wdata;
    cmd_wstrb = strb; cmd_mask = mask; cmd_match = match; cmd_valid = 1;
    check("cmd_ready_idle", cmd_ready, 1'b1);
    @(posedge ACLK); #1;
    cmd_valid = 0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 200) begin
      @(posedge ACLK); #1;
      lat++;
    end
    if (!rsp_valid) check("rsp_wait_expired", 1'b0, 1'b1);
  endtask

  task automatic take_rsp();
    rsp_ready = 1;
    @(posedge ACLK); #1;
    rsp_ready = 0;
  endtask

  task automatic do_txn(input string tag, input logic wr, input logic poll,
                        input logic [7:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic [31:0] mask,
                        input logic [31:0] match, input logic [31:0] exp_rdata,
                        input logic [1:0] exp_resp, input logic exp_to, input int exp_lat);
    int lat;
    logic [31:0] e;
    exp_q.push_back(exp_rdata);
    send_cmd(wr, poll, addr, wdata, strb, mask, match);
    wait_rsp(lat);
    e = exp_q.pop_front();
    check({tag, "_rdata"}, rsp_rdata, e);
    check({tag, "_resp"}, rsp_resp, exp_resp);
    check({tag, "_timeout"}, rsp_timeout, exp_to);
    check({tag, "_latency"}, lat, exp_lat);
    take_rsp();
  endtask

  // ------------------------------------------------------------ watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------------------ stimulus
  initial begin
    int ar0, hs0, lat;
    logic stable;
    n_cmp = 0; n_err = 0;
    ARESETN = 0; cmd_valid = 0; cmd_write = 0; cmd_poll = 0; cmd_addr = 0;
    cmd_wdata = 0; cmd_wstrb = 0; cmd_mask = 0; cmd_match = 0; rsp_ready = 0;
    aw_delay = 0; w_delay = 0; ar_delay = 0; scr_len = 0; scr_base = 0;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;

    repeat (3) @(posedge ACLK);
    #1;
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_valids", {AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid}, 6'b0);
    check("rst_axi_payload", {AWADDR, WDATA, WSTRB, ARADDR}, 52'h0);
    check("rst_rsp", {rsp_rdata, rsp_resp, rsp_timeout}, 35'h0);
    check("rst_state", dbg_state, 3'd0);
    @(negedge ACLK);
    ARESETN = 1;

    // Zero-wait write of the control word.
    send_cmd(1, 0, 8'h00, 32'h0000_0003, 4'hF, 0, 0);
    check("wr_t1_valids", {AWVALID, WVALID}, 2'b11);
    check("wr_t1_payload", {AWADDR, WDATA, WSTRB}, {8'h00, 32'h3, 4'hF});
    @(posedge ACLK); #1;
    check("wr_t2_bready", {AWVALID, WVALID, BREADY}, 3'b001);
    @(posedge ACLK); #1;
    check("wr_t3_rsp_valid", rsp_valid, 1'b1);
    check("wr_t3_rsp", {rsp_rdata, rsp_resp, rsp_timeout}, 35'h0);
    take_rsp();
    check("ctrl_rst_n_ap_start", {rst_n_o, ap_start_o}, 2'b11);

    // Zero-wait read-back.
    send_cmd(0, 0, 8'h00, 0, 0, 0, 0);
    check("rd_t1_arvalid", {ARVALID, ARADDR}, {1'b1, 8'h00});
    @(posedge ACLK); #1;
    check("rd_t2_rready", {ARVALID, RREADY}, 2'b01);
    @(posedge ACLK); #1;
    check("rd_t3_rsp", {rsp_valid, rsp_rdata, rsp_resp}, {1'b1, 32'h3, 2'b00});
    take_rsp();

    // AW stalled 3 cycles, W immediate.
    aw_delay = 3;
    send_cmd(1, 0, 8'h08, 32'h1234_5678, 4'hF, 0, 0);
    check("ind_t1_valids", {AWVALID, WVALID}, 2'b11);
    for (int k = 0; k < 3; k++) begin
      @(posedge ACLK); #1;
      check($sformatf("ind_aw_hold_%0d", k), {WVALID, AWVALID, BREADY, AWADDR},
            {1'b0, 1'b1, 1'b0, 8'h08});
    end
    @(posedge ACLK); #1;
    check("ind_bready_after_both", {AWVALID, WVALID, BREADY}, 3'b001);
    wait_rsp(lat);
    check("ind_rsp_latency", lat, 2);
    check("ind_resp", rsp_resp, 2'b00);
    take_rsp();
    check("ind_slave_reg", regs[2], 32'h1234_5678);
    aw_delay = 0;

    // Partial strobe; first write carries cmd_poll, which must be ignored.
    ar0 = ar_cnt;
    do_txn("pstrb_full", 1, 1, 8'h14, 32'h1122_3344, 4'hF, 32'h1, 32'h1, 32'h0, 2'b00, 0, 3);
    check("wr_poll_ignored_no_ar", ar_cnt - ar0, 0);
    do_txn("pstrb_part", 1, 0, 8'h14, 32'hAABB_CCDD, 4'h3, 0, 0, 32'h0, 2'b00, 0, 3);
    check("pstrb_slave_reg", regs[5], 32'h1122_CCDD);
    do_txn("pstrb_readback", 0, 0, 8'h14, 0, 0, 0, 0, 32'h1122_CCDD, 2'b00, 0, 3);

    // Poll match on the third read: 3 + 2*2 cycles.
    scr_data[0] = 0; scr_data[1] = 0; scr_data[2] = 1;
    scr_resp[0] = 0; scr_resp[1] = 0; scr_resp[2] = 0;
    scr_base = ar_cnt; scr_len = 3; ar0 = ar_cnt;
    do_txn("poll_match", 0, 1, 8'h10, 0, 0, 32'h1, 32'h1, 32'h1, 2'b00, 0, 7);
    check("poll_match_reads", ar_cnt - ar0, 3);

    // Poll exhausts POLL_MAX = 4 reads.
    for (int i = 0; i < 8; i++) begin scr_data[i] = 0; scr_resp[i] = 0; end
    scr_base = ar_cnt; scr_len = 8; ar0 = ar_cnt;
    do_txn("poll_timeout", 0, 1, 8'h10, 0, 0, 32'h1, 32'h1, 32'h0, 2'b00, 1, 9);
    check("poll_timeout_reads", ar_cnt - ar0, 4);

    // Match on the very last permitted read is not a timeout.
    scr_data[3] = 32'h0000_0001;
    scr_base = ar_cnt; scr_len = 8; ar0 = ar_cnt;
    do_txn("poll_last_hit", 0, 1, 8'h10, 0, 0, 32'h1, 32'h1, 32'h1, 2'b00, 0, 9);
    check("poll_last_hit_reads", ar_cnt - ar0, 4);

    // Error response ends the poll after one read.
    scr_data[0] = 0; scr_resp[0] = 2'b10;
    scr_base = ar_cnt; scr_len = 1; ar0 = ar_cnt;
    do_txn("poll_slverr", 0, 1, 8'h10, 0, 0, 32'h1, 32'h1, 32'h0, 2'b10, 0, 3);
    check("poll_slverr_reads", ar_cnt - ar0, 1);
    scr_len = 0;

    // Response held with rsp_ready low for 5 cycles.
    send_cmd(0, 0, 8'h00, 0, 0, 0, 0);
    wait_rsp(lat);
    hs0 = aw_cnt + w_cnt + b_cnt + ar_cnt + r_cnt;
    stable = 1;
    repeat (5) begin
      @(posedge ACLK); #1;
      if (!rsp_valid || rsp_rdata !== 32'h3 || rsp_resp !== 2'b00 || rsp_timeout !== 1'b0 ||
          AWVALID || WVALID || ARVALID || cmd_ready)
        stable = 0;
    end
    check("hold_rsp_stable", stable, 1'b1);
    check("hold_no_axi_hs", aw_cnt + w_cnt + b_cnt + ar_cnt + r_cnt, hs0);
    take_rsp();
    check("b2b_cmd_ready_u1", cmd_ready, 1'b1);
    do_txn("b2b_read", 0, 0, 8'h08, 0, 0, 0, 0, 32'h1234_5678, 2'b00, 0, 3);

    // Reset pulse while ARVALID is high; slave is reset alongside.
    ar_delay = 5;
    send_cmd(0, 0, 8'h14, 0, 0, 0, 0);
    check("rst_mid_arvalid_before", ARVALID, 1'b1);
    #2;
    ARESETN = 0;
    #1;
    check("rst_mid_arvalid_async", ARVALID, 1'b0);
    @(negedge ACLK); #1;
    ARESETN = 1;
    ar_delay = 0;
    @(posedge ACLK); #1;
    check("rst_mid_cmd_ready", {cmd_ready, dbg_state}, {1'b1, 3'd0});
    do_txn("post_rst_read", 0, 0, 8'h14, 0, 0, 0, 0, 32'h0, 2'b00, 0, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
